aes128_enc_sequencer: RTL

//  Sequences one AES-128 block encryption over a shared RV64 AES datapath (aes64 ops).

---
 rtl/aes128_enc_sequencer.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/aes128_enc_sequencer.sv
// -----------------------------------------------------------------------------
// aes128_enc_sequencer
//
// Sequences one AES-128 block encryption over a shared 64-bit AES datapath.
// Each round issues five datapath ops in order: ENC lo, ENC hi, KS1, KS2, KS2.
// The ENC ops produce the SubBytes/ShiftRows(/MixColumns) result one doubleword
// at a time. KS1/KS2 expand the next round key on the fly. AddRoundKey is
// applied locally once the new key halves are known. Ten rounds give 50 ops.
//
// Parameters
//   CLEAR_KEYS  1: zero state/key/temp registers on the response handshake
//               0: leave their contents in place
//
// Ports
//   g_clk, g_rst          clock (rising edge), async active-high reset
//   req_valid/req_ready   block request handshake (ready only when idle)
//   req_key, req_pt       128-bit key / plaintext, byte i at [8i+7:8i]
//   rsp_valid/rsp_ready   ciphertext handshake
//   rsp_ct                ciphertext, same byte order, zero unless valid
//   busy                  high from request accept to response handshake
//   dp_valid/dp_ready     datapath op handshake (dp_rd sampled on ready)
//   dp_hi, dp_mix         ENC op: high doubleword select, MixColumns enable
//   dp_op_enc/ks1/ks2     one-hot op select
//   dp_rs1, dp_rs2        datapath operands (rs2[3:0] = rcon index for KS1)
//   dp_rd                 datapath result
// -----------------------------------------------------------------------------
module aes128_enc_sequencer #(
    parameter bit CLEAR_KEYS = 1'b1
) (
    input  logic         g_clk,
    input  logic         g_rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [127:0] req_key,
    input  logic [127:0] req_pt,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_ct,
    output logic         busy,
    output logic         dp_valid,
    input  logic         dp_ready,
    output logic         dp_hi,
    output logic         dp_mix,
    output logic         dp_op_enc,
    output logic         dp_op_ks1,
    output logic         dp_op_ks2,
    output logic [63:0]  dp_rs1,
    output logic [63:0]  dp_rs2,
    input  logic [63:0]  dp_rd
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENC_LO,
        ST_ENC_HI,
        ST_KS1,
        ST_KS2A,
        ST_KS2B,
        ST_DONE
    } state_t;

    localparam logic [3:0] LAST_RND = 4'd10;

    state_t      state;
    state_t      state_nxt;

    // s1:s0 cipher state (s0 = bytes 0..7), k1:k0 current round key,
    // t holds ENC-hi then the KS1 word, e holds ENC-lo until AddRoundKey.
    logic [63:0] s0, s1, k0, k1, t, e;
    logic [3:0]  rnd;

    // -------------------------------------------------------------------------
    // Next state and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default first, so no path through the
        // case statement can leave a signal unassigned and infer a latch.
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_ct    = '0;
        busy      = 1'b1;
        dp_valid  = 1'b0;
        dp_hi     = 1'b0;
        dp_mix    = 1'b0;
        dp_op_enc = 1'b0;
        dp_op_ks1 = 1'b0;
        dp_op_ks2 = 1'b0;
        dp_rs1    = '0;
        dp_rs2    = '0;

        unique case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) state_nxt = ST_ENC_LO;
            end
            ST_ENC_LO: begin
                dp_valid  = 1'b1;
                dp_op_enc = 1'b1;
                dp_mix    = (rnd != LAST_RND);
                dp_rs1    = s0;
                dp_rs2    = s1;
                if (dp_ready) state_nxt = ST_ENC_HI;
            end
            ST_ENC_HI: begin
                dp_valid  = 1'b1;
                dp_op_enc = 1'b1;
                dp_hi     = 1'b1;
                dp_mix    = (rnd != LAST_RND);
                dp_rs1    = s0;
                dp_rs2    = s1;
                if (dp_ready) state_nxt = ST_KS1;
            end
            ST_KS1: begin
                dp_valid  = 1'b1;
                dp_op_ks1 = 1'b1;
                dp_rs1    = k1;
                // Round r uses round constant index r-1.
                dp_rs2    = {60'b0, rnd - 4'd1};
                if (dp_ready) state_nxt = ST_KS2A;
            end
            ST_KS2A: begin
                dp_valid  = 1'b1;
                dp_op_ks2 = 1'b1;
                dp_rs1    = t;
                dp_rs2    = k0;
                if (dp_ready) state_nxt = ST_KS2B;
            end
            ST_KS2B: begin
                dp_valid  = 1'b1;
                dp_op_ks2 = 1'b1;
                dp_rs1    = k0;
                dp_rs2    = k1;
                if (dp_ready) state_nxt = (rnd == LAST_RND) ? ST_DONE : ST_ENC_LO;
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                rsp_ct    = {s1, s0};
                if (rsp_ready) state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge g_clk or posedge g_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (g_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // -------------------------------------------------------------------------
    // Cipher state, round key and temporaries
    // -------------------------------------------------------------------------
    always_ff @(posedge g_clk or posedge g_rst) begin
        // NOTE: the data registers are reset as well, so key material from an
        // interrupted request never survives a reset.
        if (g_rst) begin
            s0  <= '0;
            s1  <= '0;
            k0  <= '0;
            k1  <= '0;
            t   <= '0;
            e   <= '0;
            rnd <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        {s1, s0} <= req_pt ^ req_key;
                        {k1, k0} <= req_key;
                        rnd      <= 4'd1;
                    end
                end
                ST_ENC_LO: begin
                    if (dp_ready) e <= dp_rd;
                end
                ST_ENC_HI: begin
                    if (dp_ready) t <= dp_rd;
                end
                ST_KS1: begin
                    // Park ENC-hi in s1 so t can take the KS1 result.
                    if (dp_ready) begin
                        s1 <= t;
                        t  <= dp_rd;
                    end
                end
                ST_KS2A: begin
                    if (dp_ready) k0 <= dp_rd;
                end
                ST_KS2B: begin
                    // AddRoundKey with the freshly expanded key halves.
                    if (dp_ready) begin
                        k1 <= dp_rd;
                        s0 <= e ^ k0;
                        s1 <= s1 ^ dp_rd;
                        if (rnd != LAST_RND) rnd <= rnd + 4'd1;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready && CLEAR_KEYS) begin
                        s0 <= '0;
                        s1 <= '0;
                        k0 <= '0;
                        k1 <= '0;
                        t  <= '0;
                        e  <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
